calc_core_param: RTL and testbench

//  Parametrised successor of the keypad calculator datapath. It replaces the separate FSM, register bank,

---
 rtl/calc_core_param.sv | 188 ++++++++++++++++++
 tb/tb_calc_core_param.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_core_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | calc_core_param                                                            |
// | Keypad calculator core: hex operand entry, stack register file, ALU with   |
// | multi-cycle shift-add multiply.                                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module calc_core_param #(
  parameter int W  = 16,
  parameter int AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          key_valid_i,
  input  logic [3:0]    key_val_i,
  input  logic          mode_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o,
  output logic [W-1:0]  disp_data_o,
  output logic          disp_we_o,
  output logic          busy_o,
  output logic          drop_o,
  output logic          err_o,
  output logic [3:0]    led_op_o,
  output logic [AW-1:0] ptr_o
);

  localparam int DEPTH = 2**AW;
  localparam int CW    = $clog2(W);
  localparam logic [W-1:0]  SHIFT_LIM = W'(W);
  localparam logic [AW:0]   DEPTH_MAX = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] MUL_LAST  = CW'(W-1);
  localparam logic [3:0]    KEY_ENTER = 4'hF;
  localparam logic [3:0]    KEY_CLEAR = 4'hE;
  localparam logic [2:0]    OP_MUL    = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d, a_q, a_d, b_q, b_d, res_q, res_d, disp_q, disp_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW:0]     depth_q, depth_d;
  logic [2:0]      op_q, op_d;
  logic [3:0]      led_q, led_d;
  logic            err_q, err_d, dwe_q, dwe_d, drop_q, drop_d;
  logic [2*W-1:0]  mc_q, mc_d, prod_q, prod_d;
  logic [W-1:0]    mp_q, mp_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    regs_q [DEPTH];

  logic            w_reg_we;
  logic [AW-1:0]   w_reg_waddr, w_top;
  logic [W-1:0]    w_reg_wdata, w_alu;
  logic [2*W-1:0]  w_prod_next;

  assign w_top       = ptr_q - 1'b1;
  assign w_prod_next = mp_q[0] ? (prod_q + mc_q) : prod_q;

  always_comb begin
    w_alu = '0;
    case (op_q)
      3'd0:    w_alu = a_q + b_q;
      3'd1:    w_alu = a_q - b_q;
      3'd2:    w_alu = a_q & b_q;
      3'd3:    w_alu = a_q | b_q;
      3'd4:    w_alu = a_q ^ b_q;
      3'd5:    w_alu = (b_q >= SHIFT_LIM) ? '0 : (a_q << b_q[CW-1:0]);
      3'd6:    w_alu = (b_q >= SHIFT_LIM) ? '0 : (a_q >> b_q[CW-1:0]);
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    state_d = state_q; acc_d = acc_q; a_d = a_q; b_d = b_q; res_d = res_q;
    disp_d = disp_q; ptr_d = ptr_q; depth_d = depth_q; op_d = op_q; led_d = led_q;
    err_d = err_q; mc_d = mc_q; prod_d = prod_q; mp_d = mp_q; cnt_d = cnt_q;
    dwe_d = 1'b0; drop_d = 1'b0;
    w_reg_we = 1'b0; w_reg_waddr = ptr_q; w_reg_wdata = acc_q;
    case (state_q)
      S_IDLE: begin
        if (key_valid_i && !mode_i) begin
          if (|acc_q[W-1:W-4]) begin
            err_d = 1'b1;
          end else begin
            acc_d  = {acc_q[W-5:0], key_val_i};
            disp_d = {acc_q[W-5:0], key_val_i};
            dwe_d  = 1'b1;
          end
        end else if (key_valid_i) begin
          if (key_val_i == KEY_ENTER) begin
            w_reg_we = 1'b1;
            ptr_d    = ptr_q + 1'b1;
            depth_d  = (depth_q == DEPTH_MAX) ? depth_q : depth_q + 1'b1;
            acc_d    = '0;
            disp_d   = '0;
            dwe_d    = 1'b1;
            led_d    = key_val_i;
          end else if (key_val_i == KEY_CLEAR) begin
            acc_d   = '0;
            ptr_d   = '0;
            depth_d = '0;
            err_d   = 1'b0;
            disp_d  = '0;
            dwe_d   = 1'b1;
            led_d   = key_val_i;
          end else if (!key_val_i[3]) begin
            if (depth_q == '0) begin
              err_d = 1'b1;
            end else begin
              a_d     = regs_q[w_top];
              b_d     = acc_q;
              op_d    = key_val_i[2:0];
              led_d   = key_val_i;
              mc_d    = {{W{1'b0}}, regs_q[w_top]};
              mp_d    = acc_q;
              prod_d  = '0;
              cnt_d   = '0;
              state_d = S_EXEC;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_EXEC: begin
        drop_d = key_valid_i;
        if (op_q == OP_MUL) begin
          // One multiplier bit per cycle; the last partial product is folded in on exit.
          prod_d = w_prod_next;
          mc_d   = mc_q << 1;
          mp_d   = mp_q >> 1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == MUL_LAST) begin
            res_d   = w_prod_next[W-1:0];
            disp_d  = w_prod_next[W-1:0];
            dwe_d   = 1'b1;
            err_d   = err_q | (|w_prod_next[2*W-1:W]);
            state_d = S_WB;
          end
        end else begin
          res_d   = w_alu;
          disp_d  = w_alu;
          dwe_d   = 1'b1;
          state_d = S_WB;
        end
      end
      S_WB: begin
        drop_d      = key_valid_i;
        w_reg_we    = 1'b1;
        w_reg_waddr = w_top;
        w_reg_wdata = res_q;
        acc_d       = '0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE; acc_q <= '0; a_q <= '0; b_q <= '0; res_q <= '0; disp_q <= '0;
      ptr_q <= '0; depth_q <= '0; op_q <= '0; led_q <= '0; err_q <= 1'b0;
      dwe_q <= 1'b0; drop_q <= 1'b0; mc_q <= '0; prod_q <= '0; mp_q <= '0; cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d; acc_q <= acc_d; a_q <= a_d; b_q <= b_d; res_q <= res_d;
      disp_q <= disp_d; ptr_q <= ptr_d; depth_q <= depth_d; op_q <= op_d; led_q <= led_d;
      err_q <= err_d; dwe_q <= dwe_d; drop_q <= drop_d; mc_q <= mc_d; prod_q <= prod_d;
      mp_q <= mp_d; cnt_q <= cnt_d;
      if (w_reg_we) regs_q[w_reg_waddr] <= w_reg_wdata;
    end
  end

  assign rd_data_o   = regs_q[rd_addr_i];
  assign disp_data_o = disp_q;
  assign disp_we_o   = dwe_q;
  assign busy_o      = (state_q != S_IDLE);
  assign drop_o      = drop_q;
  assign err_o       = err_q;
  assign led_op_o    = led_q;
  assign ptr_o       = ptr_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_core_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_calc_core_param                                                         |
// | Randomized and directed bench for calc_core_param against a keypress model.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_calc_core_param;
  localparam int W  = 16;
  localparam int AW = 5;

  logic          clk_i = 1'b0;
  logic          rst_i, key_valid_i, mode_i;
  logic [3:0]    key_val_i;
  logic [AW-1:0] rd_addr_i;
  logic [W-1:0]  rd_data_o, disp_data_o;
  logic          disp_we_o, busy_o, drop_o, err_o;
  logic [3:0]    led_op_o;
  logic [AW-1:0] ptr_o;

  calc_core_param #(.W(W), .AW(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .key_valid_i(key_valid_i), .key_val_i(key_val_i),
    .mode_i(mode_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .disp_data_o(disp_data_o), .disp_we_o(disp_we_o), .busy_o(busy_o), .drop_o(drop_o),
    .err_o(err_o), .led_op_o(led_op_o), .ptr_o(ptr_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int we_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Keypress-level model: state after each clock edge, busy tracked as cycles remaining.
  logic [15:0] m_regs [32];
  logic [15:0] m_acc, m_disp, m_res;
  logic [4:0]  m_ptr;
  logic [3:0]  m_led;
  logic        m_err, m_we, m_drop, m_ovf;
  int          m_depth, m_busy;

  task automatic model_step();
    logic [15:0] a, b;
    logic [31:0] p;
    logic [4:0]  top;
    m_we = 1'b0; m_drop = 1'b0;
    top = m_ptr - 5'd1;
    if (rst_i) begin
      m_acc = 0; m_ptr = 0; m_depth = 0; m_disp = 0; m_err = 0; m_led = 0;
      m_busy = 0; m_res = 0; m_ovf = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
    end else if (m_busy != 0) begin
      if (key_valid_i) m_drop = 1'b1;
      m_busy--;
      if (m_busy == 1) begin
        m_disp = m_res; m_we = 1'b1;
        if (m_ovf) m_err = 1'b1;
      end else if (m_busy == 0) begin
        m_regs[top] = m_res; m_acc = 0;
      end
    end else if (key_valid_i && !mode_i) begin
      if (m_acc[15:12] != 0) m_err = 1'b1;
      else begin
        m_acc = {m_acc[11:0], key_val_i}; m_disp = m_acc; m_we = 1'b1;
      end
    end else if (key_valid_i) begin
      if (key_val_i == 4'hF) begin
        m_regs[m_ptr] = m_acc; m_ptr = m_ptr + 5'd1;
        if (m_depth < 32) m_depth++;
        m_acc = 0; m_disp = 0; m_we = 1'b1; m_led = 4'hF;
      end else if (key_val_i == 4'hE) begin
        m_acc = 0; m_ptr = 0; m_depth = 0; m_err = 0; m_disp = 0; m_we = 1'b1; m_led = 4'hE;
      end else if (key_val_i < 4'h8) begin
        if (m_depth == 0) m_err = 1'b1;
        else begin
          a = m_regs[top]; b = m_acc; m_ovf = 1'b0; p = 0;
          case (key_val_i)
            4'h0: m_res = a + b;
            4'h1: m_res = a - b;
            4'h2: m_res = a & b;
            4'h3: m_res = a | b;
            4'h4: m_res = a ^ b;
            4'h5: m_res = (b >= 16) ? 16'h0 : (a << b);
            4'h6: m_res = (b >= 16) ? 16'h0 : (a >> b);
            default: begin
              p = 32'(a) * 32'(b);
              m_res = p[15:0];
              m_ovf = (p[31:16] != 0);
            end
          endcase
          m_led  = key_val_i;
          m_busy = (key_val_i == 4'h7) ? W + 1 : 2;
        end
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  always @(posedge clk_i) begin
    model_step();
    #1;
    if (disp_we_o) we_cnt++;
    chk("disp_data", 32'(disp_data_o), 32'(m_disp));
    chk("disp_we",   32'(disp_we_o),   32'(m_we));
    chk("busy",      32'(busy_o),      32'(m_busy != 0));
    chk("drop",      32'(drop_o),      32'(m_drop));
    chk("err",       32'(err_o),       32'(m_err));
    chk("led_op",    32'(led_op_o),    32'(m_led));
    chk("ptr",       32'(ptr_o),       32'(m_ptr));
    chk("rd_data",   32'(rd_data_o),   32'(m_regs[rd_addr_i]));
  end

  task automatic press(input logic m, input logic [3:0] v);
    @(negedge clk_i);
    key_valid_i = 1'b1; mode_i = m; key_val_i = v;
    @(negedge clk_i);
    key_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("wait_idle", 32'(busy_o), 32'd0);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    int  nbusy;
    bit  drop_seen;
    int  r;
    rst_i = 1'b1; key_valid_i = 1'b0; mode_i = 1'b0; key_val_i = 4'h0; rd_addr_i = '0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    chk("lit_reset_ptr",  32'(ptr_o), 32'd0);
    chk("lit_reset_disp", 32'(disp_data_o), 32'd0);
    chk("lit_reset_err",  32'(err_o), 32'd0);

    we_cnt = 0;
    press(0, 4'h1); press(0, 4'h2); press(0, 4'h3);
    chk("lit_digits_disp", 32'(disp_data_o), 32'h0123);
    chk("lit_digits_we",   32'(we_cnt), 32'd3);

    press(1, 4'hF);
    press(0, 4'h0); press(0, 4'h0); press(0, 4'h1); press(0, 4'h1);
    press(1, 4'h0);
    wait_idle();
    chk("lit_add_reg0", 32'(rd_data_o), 32'h0134);
    chk("lit_add_disp", 32'(disp_data_o), 32'h0134);
    chk("lit_add_ptr",  32'(ptr_o), 32'd1);

    press(1, 4'hE);
    press(0, 4'h1); press(0, 4'h0); press(0, 4'h0); press(1, 4'hF);
    press(0, 4'h1); press(0, 4'h0); press(0, 4'h0);
    press(1, 4'h7);
    nbusy = 0; drop_seen = 0;
    while (busy_o && nbusy < 40) begin
      nbusy++;
      if (nbusy == 5) begin key_valid_i = 1'b1; mode_i = 1'b0; key_val_i = 4'h7; end
      if (nbusy == 6) begin key_valid_i = 1'b0; drop_seen = drop_o; end
      @(negedge clk_i);
    end
    chk("lit_mul_busy", 32'(nbusy), 32'd17);
    chk("lit_mul_drop", 32'(drop_seen), 32'd1);
    chk("lit_mul_err",  32'(err_o), 32'd1);
    chk("lit_mul_reg0", 32'(rd_data_o), 32'h0000);

    do_reset();
    press(1, 4'h1);
    chk("lit_nodepth_err", 32'(err_o), 32'd1);
    chk("lit_nodepth_busy", 32'(busy_o), 32'd0);
    press(1, 4'hE);
    chk("lit_clear_err", 32'(err_o), 32'd0);
    press(1, 4'h9);
    chk("lit_reserved_err", 32'(err_o), 32'd1);

    press(1, 4'hE);
    press(0, 4'h1); press(0, 4'h2); press(0, 4'h3); press(0, 4'h4); press(0, 4'h5);
    chk("lit_ovf_err",  32'(err_o), 32'd1);
    chk("lit_ovf_disp", 32'(disp_data_o), 32'h1234);
    press(1, 4'hE);
    press(0, 4'h8); press(0, 4'h0); press(0, 4'h0); press(0, 4'h0); press(1, 4'hF);
    press(0, 4'h1); press(0, 4'h0);
    press(1, 4'h5);
    wait_idle();
    chk("lit_shl_reg0", 32'(rd_data_o), 32'h0000);
    chk("lit_shl_led",  32'(led_op_o), 32'h5);

    do_reset();
    for (int i = 0; i < 33; i++) press(1, 4'hF);
    chk("lit_wrap_ptr", 32'(ptr_o), 32'd1);
    press(0, 4'h3);
    press(1, 4'h7);
    we_cnt = 0;
    repeat (5) @(negedge clk_i);
    do_reset();
    repeat (20) @(negedge clk_i);
    chk("lit_rstmul_busy", 32'(busy_o), 32'd0);
    chk("lit_rstmul_reg0", 32'(rd_data_o), 32'h0000);
    chk("lit_rstmul_we",   32'(we_cnt), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      rst_i       = ($urandom_range(0, 999) == 0);
      rd_addr_i   = AW'($urandom_range(0, 31));
      key_valid_i = ($urandom_range(0, 2) == 0);
      mode_i      = $urandom_range(0, 1) == 1;
      if (!mode_i) key_val_i = 4'($urandom_range(0, 15));
      else begin
        r = $urandom_range(0, 15);
        if (r < 2)       key_val_i = 4'hE;
        else if (r < 6)  key_val_i = 4'hF;
        else if (r < 14) key_val_i = 4'($urandom_range(0, 7));
        else             key_val_i = 4'($urandom_range(8, 13));
      end
    end
    @(negedge clk_i);
    rst_i = 1'b0; key_valid_i = 1'b0;
    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
